// File: rtl/word_serial_pkg.sv
// Shared definitions for the word-serial transmitter.
//   tx_state_t : transmitter FSM states (PARITY is only used when
//                WORD_SERIAL_TX_PARITY_EN is defined)
//   WORD_W     : default datapath word width
package word_serial_pkg;

  localparam int unsigned WORD_W = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/word_serial_tx_bit_timer.sv
// bit_timer: counts the clock cycles of one bit period.
//   CLK     in  clock
//   clear   in  asynchronous active-high reset
//   restart in  restart the period from cycle 0
//   run     in  count enable
//   tick    out high in the last cycle of the period (while run)
module bit_timer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic CLK,
  input  logic clear,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/word_serial_tx.sv
// word_serial_tx: parallel-to-serial transmitter with valid/ready input.
// Optional feature: define WORD_SERIAL_TX_PARITY_EN to append an even-parity
// bit period after the data bits.
//   CLK    in  clock (rising edge)
//   clear  in  asynchronous active-high reset
//   in     in  word to send, sampled on the accept edge
//   load   in  word-valid request
//   ready  out high when a word can be accepted
//   sdata  out serial data, 0 when idle
//   sframe out high during every bit period of a word
//   done   out one-cycle pulse after the last bit period
module word_serial_tx
  import word_serial_pkg::*;
#(
  parameter int unsigned WIDTH      = WORD_W,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             ready,
  output logic             sdata,
  output logic             sframe,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic             tick;
  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic             next_bit;
  logic             first_bit;
`ifdef WORD_SERIAL_TX_PARITY_EN
  logic             par;
`endif

  assign accept = load && ready;

  // sdata is registered, so the bit that will be on the line after the
  // next shift is taken from the register before it shifts.
  always_comb begin
    shifted   = '0;
    next_bit  = 1'b0;
    first_bit = 1'b0;
    if (MSB_FIRST != 0) begin
      shifted   = shreg << 1;
      next_bit  = shreg[WIDTH-2];
      first_bit = in[WIDTH-1];
    end else begin
      shifted   = shreg >> 1;
      next_bit  = shreg[1];
      first_bit = in[0];
    end
  end

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .clear  (clear),
    .restart(accept),
    .run    (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      ready  <= 1'b1;
      sdata  <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= in;
            bitcnt <= '0;
            sdata  <= first_bit;
            sframe <= 1'b1;
            ready  <= 1'b0;
            state  <= SHIFT;
`ifdef WORD_SERIAL_TX_PARITY_EN
            par    <= ^in;
`endif
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bitcnt == BW'(WIDTH - 1)) begin
`ifdef WORD_SERIAL_TX_PARITY_EN
              sdata <= par;
              state <= PARITY;
`else
              sdata  <= 1'b0;
              sframe <= 1'b0;
              ready  <= 1'b1;
              done   <= 1'b1;
              state  <= IDLE;
`endif
            end else begin
              shreg  <= shifted;
              sdata  <= next_bit;
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        PARITY: begin
`ifdef WORD_SERIAL_TX_PARITY_EN
          if (tick) begin
            sdata  <= 1'b0;
            sframe <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b1;
            state  <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serial_tx.sv
module tb_word_serial_tx;

`ifdef WORD_SERIAL_TX_PARITY_EN
  localparam int unsigned NBITS = 19;
`else
  localparam int unsigned NBITS = 18;
`endif

  logic        CLK = 1'b0;
  logic        clear;
  logic [17:0] in_a, in_b;
  logic        load_a, load_b;
  logic        ready_a, sdata_a, sframe_a, done_a;
  logic        ready_b, sdata_b, sframe_b, done_b;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 CLK = ~CLK;

  // A: default MSB-first, one cycle per bit
  word_serial_tx #(
    .WIDTH(18), .BIT_CYCLES(1), .MSB_FIRST(1)
  ) dut_a (
    .CLK(CLK), .clear(clear), .in(in_a), .load(load_a),
    .ready(ready_a), .sdata(sdata_a), .sframe(sframe_a), .done(done_a)
  );

  // B: LSB-first, three cycles per bit
  word_serial_tx #(
    .WIDTH(18), .BIT_CYCLES(3), .MSB_FIRST(0)
  ) dut_b (
    .CLK(CLK), .clear(clear), .in(in_b), .load(load_b),
    .ready(ready_b), .sdata(sdata_b), .sframe(sframe_b), .done(done_b)
  );

  // {ready, sframe, sdata, done}
  function automatic logic [3:0] outs(input int which);
    if (which == 1) return {ready_b, sframe_b, sdata_b, done_b};
    return {ready_a, sframe_a, sdata_a, done_a};
  endfunction

  function automatic int unsigned bc_of(input int which);
    return (which == 1) ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic l, input logic [17:0] w);
    if (which == 1) begin
      load_b = l; in_b = w;
    end else begin
      load_a = l; in_a = w;
    end
  endtask

  // Expected per-cycle sdata values for one frame.
  task automatic push_word(input int which, input logic [17:0] w);
    bit b;
    for (int i = 0; i < 18; i++) begin
      b = (which == 1) ? w[i] : w[17-i];
      repeat (bc_of(which)) exp_q.push_back(b);
    end
`ifdef WORD_SERIAL_TX_PARITY_EN
    b = ^w;
    repeat (bc_of(which)) exp_q.push_back(b);
`endif
  endtask

  // Sample count in-frame cycles; after each sample drive load/in.
  task automatic check_bits(input int which, input int unsigned count, input string tag,
                            input logic nl, input logic [17:0] nw);
    logic e;
    for (int unsigned c = 0; c < count; c++) begin
      @(negedge CLK);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("%s_c%0d", tag, c), {28'd0, outs(which)}, {28'd0, 1'b0, 1'b1, e, 1'b0});
      drive(which, nl, nw);
    end
  endtask

  task automatic check_end(input int which, input string tag);
    @(negedge CLK);
    check({tag, "_done"}, {28'd0, outs(which)}, 32'h9);
    check({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  task automatic send(input int which, input logic [17:0] w, input string tag);
    @(negedge CLK);
    drive(which, 1'b1, w);
    push_word(which, w);
    @(posedge CLK);
    check_bits(which, NBITS * bc_of(which), tag, 1'b0, ~w);
    check_end(which, tag);
    @(negedge CLK);
    check({tag, "_idle"}, {28'd0, outs(which)}, 32'h8);
  endtask

  initial begin
    // reset with load held high
    clear = 1'b1;
    drive(0, 1'b1, 18'h3FFFF);
    drive(1, 1'b1, 18'h3FFFF);
    repeat (2) begin
      @(negedge CLK);
      check("clear_hold_a", {28'd0, outs(0)}, 32'h8);
      check("clear_hold_b", {28'd0, outs(1)}, 32'h8);
    end
    clear = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    @(negedge CLK);
    check("reset_a", {28'd0, outs(0)}, 32'h8);
    check("reset_b", {28'd0, outs(1)}, 32'h8);

    // basic MSB-first and stretched LSB-first frames
    send(0, 18'b101010101010101010, "msb");
    send(1, 18'b111100001111000011, "lsb3");

    // busy protection: second word held on load during the whole frame
    @(negedge CLK);
    drive(0, 1'b1, 18'h2AAAA);
    push_word(0, 18'h2AAAA);
    @(posedge CLK);
    check_bits(0, NBITS, "busy1", 1'b1, 18'h15555);
    check_end(0, "busy1");
    push_word(0, 18'h15555);
    @(posedge CLK);
    check_bits(0, NBITS, "busy2", 1'b0, 18'h0);
    check_end(0, "busy2");
    @(negedge CLK);
    check("busy2_idle", {28'd0, outs(0)}, 32'h8);

    // parity-sensitive words (odd and even number of ones)
    send(0, 18'b010101010101010101, "par_odd");
    send(0, 18'h00003, "par_even");
    send(1, 18'h10001, "lsb3_even");

    // abort mid-frame during bit 7
    @(negedge CLK);
    drive(0, 1'b1, 18'h3C0F1);
    push_word(0, 18'h3C0F1);
    @(posedge CLK);
    check_bits(0, 7, "abort", 1'b0, 18'h0);
    @(posedge CLK);
    #2 clear = 1'b1;
    #1 check("abort_async", {28'd0, outs(0)}, 32'h8);
    exp_q.delete();
    @(negedge CLK);
    clear = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("abort_nodone", {28'd0, outs(0)}, 32'h8);
    end
    send(0, 18'h3C0F1, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
